// File: rtl/tape_arbiter.sv
// tape_arbiter: shares the single-port tape RAM between CPU and host debug port.
// Optional TAPE_ARB_HOST_LOCK_EN adds host_lock to lock the CPU out.
module tape_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req_valid,
  input  logic              cpu_req_write,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic [DATA_W-1:0] cpu_req_wdata,
  output logic              cpu_req_ready,
  output logic              cpu_rsp_valid,
  output logic [DATA_W-1:0] cpu_rsp_data,
  input  logic              host_req_valid,
  input  logic              host_req_write,
  input  logic [ADDR_W-1:0] host_req_addr,
  input  logic [DATA_W-1:0] host_req_wdata,
`ifdef TAPE_ARB_HOST_LOCK_EN
  input  logic              host_lock,
`endif
  output logic              host_req_ready,
  output logic              host_rsp_valid,
  output logic [DATA_W-1:0] host_rsp_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0]     r_starve_cnt;
  logic              r_rsp_pending;
  logic              r_rsp_owner;
  logic              r_rsp_is_write;
  logic [DATA_W-1:0] r_wdata_echo;
  logic [DATA_W-1:0] r_cpu_rsp_data;
  logic [DATA_W-1:0] r_host_rsp_data;

  logic              w_lock;
  logic              w_starved;
  logic              w_gnt_cpu;
  logic              w_gnt_host;
  logic              w_gnt_any;
  logic [DATA_W-1:0] w_rsp_data;
  logic              w_cpu_fire;
  logic              w_host_fire;

`ifdef TAPE_ARB_HOST_LOCK_EN
  assign w_lock = host_lock;
`else
  assign w_lock = 1'b0;
`endif

  // Fixed CPU priority; host wins once it has lost LIMIT contested rounds.
  assign w_starved  = (r_starve_cnt == LIMIT);
  assign w_gnt_host = !reset && host_req_valid &&
                      (w_lock || !cpu_req_valid || w_starved);
  assign w_gnt_cpu  = !reset && !w_lock && cpu_req_valid &&
                      !(host_req_valid && w_starved);
  assign w_gnt_any  = w_gnt_cpu || w_gnt_host;

  assign cpu_req_ready  = w_gnt_cpu;
  assign host_req_ready = w_gnt_host;

  // RAM strobe is driven straight from the granted port.
  assign mem_en    = w_gnt_any;
  assign mem_we    = w_gnt_host ? host_req_write
                                : (w_gnt_cpu && cpu_req_write);
  assign mem_addr  = w_gnt_host ? host_req_addr  : cpu_req_addr;
  assign mem_wdata = w_gnt_host ? host_req_wdata : cpu_req_wdata;

  // Count contested rounds the host lost; any host grant or lock clears it.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_starve_cnt <= '0;
    end else if (w_lock || w_gnt_host) begin
      r_starve_cnt <= '0;
    end else if (host_req_valid && w_gnt_cpu && !w_starved) begin
      r_starve_cnt <= r_starve_cnt + CW'(1);
    end
  end

  // Remember who owns the access now in the RAM and how to answer it.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rsp_pending  <= 1'b0;
      r_rsp_owner    <= 1'b0;
      r_rsp_is_write <= 1'b0;
      r_wdata_echo   <= '0;
    end else begin
      r_rsp_pending <= w_gnt_any;
      if (w_gnt_any) begin
        r_rsp_owner    <= w_gnt_host;
        r_rsp_is_write <= mem_we;
        r_wdata_echo   <= mem_wdata;
      end
    end
  end

  // Reads return RAM data, writes echo what was written; reset drops it.
  assign w_rsp_data  = r_rsp_is_write ? r_wdata_echo : mem_rdata;
  assign w_cpu_fire  = r_rsp_pending && !r_rsp_owner && !reset;
  assign w_host_fire = r_rsp_pending &&  r_rsp_owner && !reset;

  assign cpu_rsp_valid  = w_cpu_fire;
  assign host_rsp_valid = w_host_fire;
  assign cpu_rsp_data   = w_cpu_fire  ? w_rsp_data : r_cpu_rsp_data;
  assign host_rsp_data  = w_host_fire ? w_rsp_data : r_host_rsp_data;

  // Hold each port's last response data while it is not the owner.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cpu_rsp_data  <= '0;
      r_host_rsp_data <= '0;
    end else begin
      if (w_cpu_fire)  r_cpu_rsp_data  <= w_rsp_data;
      if (w_host_fire) r_host_rsp_data <= w_rsp_data;
    end
  end

endmodule

// File: tb/tb_tape_arbiter.sv
// tb_tape_arbiter: directed checks of tape_arbiter against a write-first RAM.
// Lock steps are compiled in only with TAPE_ARB_HOST_LOCK_EN.
module tb_tape_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_req_valid, cpu_req_write, cpu_req_ready;
  logic [15:0] cpu_req_addr;
  logic [7:0]  cpu_req_wdata;
  logic        cpu_rsp_valid;
  logic [7:0]  cpu_rsp_data;
  logic        host_req_valid, host_req_write, host_req_ready;
  logic [15:0] host_req_addr;
  logic [7:0]  host_req_wdata;
  logic        host_rsp_valid;
  logic [7:0]  host_rsp_data;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
`ifdef TAPE_ARB_HOST_LOCK_EN
  logic        host_lock;
`endif

  logic [7:0]  ram [0:65535];
  int          n_vec = 0;
  int          n_err = 0;
  logic [9:0]  exp_h;

  always #5 clock = ~clock;

  tape_arbiter #(.ADDR_W(16), .DATA_W(8), .STARVE_LIMIT(3)) dut (
    .clock          (clock),
    .reset          (reset),
    .cpu_req_valid  (cpu_req_valid),
    .cpu_req_write  (cpu_req_write),
    .cpu_req_addr   (cpu_req_addr),
    .cpu_req_wdata  (cpu_req_wdata),
    .cpu_req_ready  (cpu_req_ready),
    .cpu_rsp_valid  (cpu_rsp_valid),
    .cpu_rsp_data   (cpu_rsp_data),
    .host_req_valid (host_req_valid),
    .host_req_write (host_req_write),
    .host_req_addr  (host_req_addr),
    .host_req_wdata (host_req_wdata),
`ifdef TAPE_ARB_HOST_LOCK_EN
    .host_lock      (host_lock),
`endif
    .host_req_ready (host_req_ready),
    .host_rsp_valid (host_rsp_valid),
    .host_rsp_data  (host_rsp_data),
    .mem_en         (mem_en),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata)
  );

  // Synchronous write-first RAM.
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= mem_we ? mem_wdata : ram[mem_addr];
    end
  end

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkd(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chka(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cpu_drv(input logic v, input logic w,
                         input logic [15:0] a, input logic [7:0] d);
    cpu_req_valid = v;
    cpu_req_write = w;
    cpu_req_addr  = a;
    cpu_req_wdata = d;
  endtask

  task automatic host_drv(input logic v, input logic w,
                          input logic [15:0] a, input logic [7:0] d);
    host_req_valid = v;
    host_req_write = w;
    host_req_addr  = a;
    host_req_wdata = d;
  endtask

  initial begin
    reset = 1'b1;
`ifdef TAPE_ARB_HOST_LOCK_EN
    host_lock = 1'b0;
`endif
    cpu_drv(0, 0, 16'h0000, 8'h00);
    host_drv(0, 0, 16'h0000, 8'h00);
    ram[16'h0005] = 8'h7F;
    ram[16'h0020] = 8'hC0;
    ram[16'h0021] = 8'h4B;
    tick();
    tick();

    // reset state, with both requesters asking
    cpu_drv(1, 0, 16'h0020, 8'h00);
    host_drv(1, 0, 16'h0021, 8'h00);
    #1;
    chkb("rst_cpu_rdy", cpu_req_ready, 1'b0);
    chkb("rst_host_rdy", host_req_ready, 1'b0);
    chkb("rst_mem_en", mem_en, 1'b0);
    chkb("rst_cpu_rv", cpu_rsp_valid, 1'b0);
    chkb("rst_host_rv", host_rsp_valid, 1'b0);
    chkd("rst_cpu_rd", cpu_rsp_data, 8'h00);
    chkd("rst_host_rd", host_rsp_data, 8'h00);
    tick();

    // CPU write 0x41 -> 0x0010, then read it back
    reset = 1'b0;
    cpu_drv(1, 1, 16'h0010, 8'h41);
    host_drv(0, 0, 16'h0000, 8'h00);
    #1;
    chkb("wr_cpu_rdy", cpu_req_ready, 1'b1);
    chkb("wr_host_rdy", host_req_ready, 1'b0);
    chkb("wr_mem_en", mem_en, 1'b1);
    chkb("wr_mem_we", mem_we, 1'b1);
    chka("wr_mem_addr", mem_addr, 16'h0010);
    chkd("wr_mem_wdata", mem_wdata, 8'h41);
    tick();
    chkb("wr_cpu_rv", cpu_rsp_valid, 1'b1);
    chkd("wr_cpu_rd", cpu_rsp_data, 8'h41);
    chkb("wr_host_rv", host_rsp_valid, 1'b0);
    cpu_drv(1, 0, 16'h0010, 8'h00);
    #1;
    chkb("rd_mem_we", mem_we, 1'b0);
    tick();
    chkb("rd_cpu_rv", cpu_rsp_valid, 1'b1);
    chkd("rd_cpu_rd", cpu_rsp_data, 8'h41);
    chkb("rd_host_rv", host_rsp_valid, 1'b0);
    cpu_drv(0, 0, 16'h0000, 8'h00);
    tick();
    chkb("idle_cpu_rv", cpu_rsp_valid, 1'b0);
    chkd("idle_cpu_hold", cpu_rsp_data, 8'h41);

    // host-only read of preloaded 0x0005
    host_drv(1, 0, 16'h0005, 8'h00);
    #1;
    chkb("h_host_rdy", host_req_ready, 1'b1);
    chkb("h_cpu_rdy", cpu_req_ready, 1'b0);
    chka("h_mem_addr", mem_addr, 16'h0005);
    tick();
    chkb("h_host_rv", host_rsp_valid, 1'b1);
    chkd("h_host_rd", host_rsp_data, 8'h7F);
    chkb("h_cpu_rv", cpu_rsp_valid, 1'b0);
    chkd("h_cpu_hold", cpu_rsp_data, 8'h41);
    host_drv(0, 0, 16'h0000, 8'h00);
    tick();
    chkb("h_idle_rv", host_rsp_valid, 1'b0);
    chkd("h_idle_hold", host_rsp_data, 8'h7F);

    // continuous contention: C,C,C,H,C,C,C,H,C,C
    exp_h = 10'b0010001000;
    cpu_drv(1, 0, 16'h0020, 8'h00);
    host_drv(1, 0, 16'h0021, 8'h00);
    for (int i = 0; i < 10; i++) begin
      #1;
      chkb("arb_host_rdy", host_req_ready, exp_h[i]);
      chkb("arb_cpu_rdy", cpu_req_ready, !exp_h[i]);
      tick();
      chkb("arb_cpu_rv", cpu_rsp_valid, !exp_h[i]);
      chkb("arb_host_rv", host_rsp_valid, exp_h[i]);
      if (exp_h[i]) chkd("arb_host_rd", host_rsp_data, 8'h4B);
      else          chkd("arb_cpu_rd", cpu_rsp_data, 8'hC0);
    end
    cpu_drv(0, 0, 16'h0000, 8'h00);
    host_drv(0, 0, 16'h0000, 8'h00);
    tick();

    // CPU read accepted, then reset the following cycle
    cpu_drv(1, 0, 16'h0010, 8'h00);
    #1;
    chkb("mr_cpu_rdy", cpu_req_ready, 1'b1);
    tick();
    reset = 1'b1;
    host_drv(1, 0, 16'h0021, 8'h00);
    #1;
    chkb("mr_cpu_rv0", cpu_rsp_valid, 1'b0);
    chkb("mr_host_rv0", host_rsp_valid, 1'b0);
    chkb("mr_cpu_rdy", cpu_req_ready, 1'b0);
    chkb("mr_host_rdy", host_req_ready, 1'b0);
    chkb("mr_mem_en", mem_en, 1'b0);
    tick();
    chkb("mr_cpu_rv1", cpu_rsp_valid, 1'b0);
    chkb("mr_host_rv1", host_rsp_valid, 1'b0);
    tick();
    reset = 1'b0;
    cpu_drv(0, 0, 16'h0000, 8'h00);
    host_drv(0, 0, 16'h0000, 8'h00);
    #1;
    chkd("mr_cpu_rd", cpu_rsp_data, 8'h00);
    chkd("mr_host_rd", host_rsp_data, 8'h00);
    tick();
    chkb("mr_cpu_rv2", cpu_rsp_valid, 1'b0);
    chkb("mr_host_rv2", host_rsp_valid, 1'b0);

    // starvation count restarts from 0: C,C,C,H
    exp_h = 10'b0000001000;
    cpu_drv(1, 0, 16'h0020, 8'h00);
    host_drv(1, 0, 16'h0021, 8'h00);
    for (int i = 0; i < 4; i++) begin
      #1;
      chkb("rs_host_rdy", host_req_ready, exp_h[i]);
      chkb("rs_cpu_rdy", cpu_req_ready, !exp_h[i]);
      tick();
      chkb("rs_host_rv", host_rsp_valid, exp_h[i]);
    end
    cpu_drv(0, 0, 16'h0000, 8'h00);
    host_drv(0, 0, 16'h0000, 8'h00);
    tick();

    // CPU write 0x22 -> addr 3, host reads addr 3 next cycle
    cpu_drv(1, 1, 16'h0003, 8'h22);
    #1;
    chkb("wh_cpu_rdy", cpu_req_ready, 1'b1);
    tick();
    chkd("wh_cpu_rd", cpu_rsp_data, 8'h22);
    cpu_drv(0, 0, 16'h0000, 8'h00);
    host_drv(1, 0, 16'h0003, 8'h00);
    #1;
    chkb("wh_host_rdy", host_req_ready, 1'b1);
    tick();
    chkb("wh_host_rv", host_rsp_valid, 1'b1);
    chkd("wh_host_rd", host_rsp_data, 8'h22);

    // host write 0x5A -> addr 7 (echo), CPU reads it back
    host_drv(1, 1, 16'h0007, 8'h5A);
    tick();
    chkb("hw_host_rv", host_rsp_valid, 1'b1);
    chkd("hw_host_rd", host_rsp_data, 8'h5A);
    host_drv(0, 0, 16'h0000, 8'h00);
    cpu_drv(1, 0, 16'h0007, 8'h00);
    tick();
    chkb("hw_cpu_rv", cpu_rsp_valid, 1'b1);
    chkd("hw_cpu_rd", cpu_rsp_data, 8'h5A);
    cpu_drv(0, 0, 16'h0000, 8'h00);
    tick();

`ifdef TAPE_ARB_HOST_LOCK_EN
    // in-flight CPU read completes under lock; host owns the RAM for 5 cycles
    cpu_drv(1, 0, 16'h0020, 8'h00);
    #1;
    chkb("lk_cpu_rdy0", cpu_req_ready, 1'b1);
    tick();
    host_lock = 1'b1;
    host_drv(1, 0, 16'h0021, 8'h00);
    #1;
    chkb("lk_cpu_rv", cpu_rsp_valid, 1'b1);
    chkd("lk_cpu_rd", cpu_rsp_data, 8'hC0);
    for (int i = 0; i < 5; i++) begin
      #1;
      chkb("lk_host_rdy", host_req_ready, 1'b1);
      chkb("lk_cpu_rdy", cpu_req_ready, 1'b0);
      tick();
      chkb("lk_host_rv", host_rsp_valid, 1'b1);
      chkd("lk_host_rd", host_rsp_data, 8'h4B);
    end
    host_lock = 1'b0;
    #1;
    chkb("ul_cpu_rdy", cpu_req_ready, 1'b1);
    chkb("ul_host_rdy", host_req_ready, 1'b0);
    tick();
    chkb("ul_cpu_rv", cpu_rsp_valid, 1'b1);
    cpu_drv(0, 0, 16'h0000, 8'h00);
    host_drv(0, 0, 16'h0000, 8'h00);
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
